// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: two-stage valid/ready RV32I instruction encoder.
// Stage 1 registers the request fields. Stage 2 registers the encoded word and
// the range-check result. Illegal requests produce out_err=1 and a zero word.
// Optional feature: define RV_ENC_ERR_COUNT_EN to add the saturating err_count
// output, which counts errored words accepted by the consumer.
module rv32i_instr_encoder #(
    parameter int OP_W      = 6,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_op,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err
`ifdef RV_ENC_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    logic               vld_p1;
    logic [OP_W-1:0]    op_p1;
    logic [4:0]         rd_p1;
    logic [4:0]         rs1_p1;
    logic [4:0]         rs2_p1;
    logic signed [31:0] imm_p1;

    logic               vld_p2;
    logic [31:0]        instr_p2;
    logic               err_p2;

    logic               adv_p1;
    logic               adv_p2;
    logic [31:0]        op_w;
    logic [31:0]        enc_instr;
    logic               enc_err;
    logic [2:0]         f3;
    logic [6:0]         f7;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // A stage may load whenever it is empty or its contents move on this cycle.
    assign adv_p2    = !vld_p2 || out_ready;
    assign adv_p1    = !vld_p1 || adv_p2;
    assign in_ready  = adv_p1;
    assign out_valid = vld_p2;
    assign out_instr = instr_p2;
    assign out_err   = err_p2;
    assign op_w      = 32'(op_p1);

    // ---- stage 1: request capture ----
    // Stage 1 valid: refilled on every advance, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    // Stage 1 data: captured only on an input handshake.
    always_ff @(posedge clk) begin
        if (in_valid && adv_p1) begin
            op_p1  <= in_op;
            rd_p1  <= in_rd;
            rs1_p1 <= in_rs1;
            rs2_p1 <= in_rs2;
            imm_p1 <= $signed(in_imm);
        end
    end

    // ---- stage 1 -> stage 2: encode and range-check ----
    // Encode the stage 1 request by format and flag out-of-range immediates.
    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        f3        = 3'b000;
        f7        = 7'b0000000;
        case (op_w) inside
            32'd0, 32'd1: begin
                enc_err   = (imm_p1[11:0] != 12'd0);
                enc_instr = {imm_p1[31:12], rd_p1,
                             op_w[0] ? 7'b0010111 : 7'b0110111};
            end
            32'd2: begin
                enc_err   = !in_range(imm_p1, -32'sd1048576, 32'sd1048574) || imm_p1[0];
                enc_instr = {imm_p1[20], imm_p1[10:1], imm_p1[11], imm_p1[19:12],
                             rd_p1, 7'b1101111};
            end
            32'd3: begin
                enc_err   = !in_range(imm_p1, -32'sd2048, 32'sd2047);
                enc_instr = {imm_p1[11:0], rs1_p1, 3'b000, rd_p1, 7'b1100111};
            end
            [32'd4:32'd9]: begin
                case (op_w)
                    32'd4:   f3 = 3'b000;
                    32'd5:   f3 = 3'b001;
                    32'd6:   f3 = 3'b100;
                    32'd7:   f3 = 3'b101;
                    32'd8:   f3 = 3'b110;
                    default: f3 = 3'b111;
                endcase
                enc_err   = !in_range(imm_p1, -32'sd4096, 32'sd4094) || imm_p1[0];
                enc_instr = {imm_p1[12], imm_p1[10:5], rs2_p1, rs1_p1, f3,
                             imm_p1[4:1], imm_p1[11], 7'b1100011};
            end
            [32'd10:32'd14]: begin
                case (op_w)
                    32'd10:  f3 = 3'b000;
                    32'd11:  f3 = 3'b001;
                    32'd12:  f3 = 3'b010;
                    32'd13:  f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
                enc_err   = !in_range(imm_p1, -32'sd2048, 32'sd2047);
                enc_instr = {imm_p1[11:0], rs1_p1, f3, rd_p1, 7'b0000011};
            end
            [32'd15:32'd17]: begin
                case (op_w)
                    32'd15:  f3 = 3'b000;
                    32'd16:  f3 = 3'b001;
                    default: f3 = 3'b010;
                endcase
                enc_err   = !in_range(imm_p1, -32'sd2048, 32'sd2047);
                enc_instr = {imm_p1[11:5], rs2_p1, rs1_p1, f3, imm_p1[4:0], 7'b0100011};
            end
            [32'd18:32'd23]: begin
                case (op_w)
                    32'd18:  f3 = 3'b000;
                    32'd19:  f3 = 3'b010;
                    32'd20:  f3 = 3'b011;
                    32'd21:  f3 = 3'b100;
                    32'd22:  f3 = 3'b110;
                    default: f3 = 3'b111;
                endcase
                enc_err   = !in_range(imm_p1, -32'sd2048, 32'sd2047);
                enc_instr = {imm_p1[11:0], rs1_p1, f3, rd_p1, 7'b0010011};
            end
            [32'd24:32'd26]: begin
                f3        = (op_w == 32'd24) ? 3'b001 : 3'b101;
                f7        = (op_w == 32'd26) ? 7'b0100000 : 7'b0000000;
                enc_err   = !in_range(imm_p1, 32'sd0, 32'sd31);
                enc_instr = {f7, imm_p1[4:0], rs1_p1, f3, rd_p1, 7'b0010011};
            end
            [32'd27:32'd36]: begin
                case (op_w)
                    32'd27, 32'd28: f3 = 3'b000;
                    32'd29:         f3 = 3'b001;
                    32'd30:         f3 = 3'b010;
                    32'd31:         f3 = 3'b011;
                    32'd32:         f3 = 3'b100;
                    32'd33, 32'd34: f3 = 3'b101;
                    32'd35:         f3 = 3'b110;
                    default:        f3 = 3'b111;
                endcase
                f7        = (op_w == 32'd28 || op_w == 32'd34) ? 7'b0100000 : 7'b0000000;
                enc_instr = {f7, rs2_p1, rs1_p1, f3, rd_p1, 7'b0110011};
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        if (enc_err) begin
            enc_instr = '0;
        end
    end

    // ---- stage 2: output register ----
    // Stage 2 loads the encoded word on advance and holds it while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            instr_p2 <= '0;
            err_p2   <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                instr_p2 <= enc_instr;
                err_p2   <= enc_err;
            end
        end
    end

`ifdef RV_ENC_ERR_COUNT_EN
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    // Count errored words as the consumer accepts them, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (vld_p2 && out_ready && err_p2) begin
            err_count <= sat_inc(err_count);
        end
    end
`endif

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Streaming RV32I instruction encoder: turns an operation index plus register and immediate fields into a 32-bit machine word.
- It is the producer-side counterpart of the core's instruction decoder.
- Used by the FPGA boot/self-test sequencer and the bench stimulus to generate instruction memory contents on chip.
- Two-stage valid/ready pipeline with full backpressure and per-instruction range checking.

Parameters:
- OP_W, 6, width of the operation index input.
- ERR_CNT_W, 16, width of the saturating error counter (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- in_op  in  OP_W  operation index (table in Behaviour).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  immediate as a full signed byte/value offset. For U-type it is the final upper value; shifts use the shamt value.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction; 0x00000000 when out_err=1.
- out_err  out  1  request was illegal (bad op or immediate out of range).
- err_count  out  ERR_CNT_W  only with RV_ENC_ERR_COUNT_EN.

Behaviour:
- Op index table:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR
  - 4-9: BEQ, BNE, BLT, BGE, BLTU, BGEU
  - 10-14: LB, LH, LW, LBU, LHU
  - 15-17: SB, SH, SW
  - 18-23: ADDI, SLTI, SLTIU, XORI, ORI, ANDI
  - 24-26: SLLI, SRLI, SRAI
  - 27-36: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  - Indices 37 and above are illegal.
- Encodings are standard RV32I:
  - Register ops use opcode 0110011.
  - SLT/SLTI use funct3 010.
  - SUB, SRA and SRAI use funct7 0100000; all other R-type and shift ops use 0000000.
- Format fields: only fields used by the op's format (R/I/S/B/U/J) are inserted; all other instruction bits are zero.
- Stage 1 (S1): a handshake occurs when in_valid && in_ready; on it, register op, rd, rs1, rs2 and imm into S1 and set s1_valid.
- Stage 2 (S2): encode and range-check S1 contents into out_instr/out_err; out_valid = s2_valid.
- Latency: an accepted request appears on out_* on the 2nd rising edge after acceptance when there is no backpressure.
- Throughput: 1 word/cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- out_* hold stable while out_valid && !out_ready.
- Range checks; any failure sets out_err=1 and out_instr=0:
  - I-type (loads, JALR, ALU-imm): imm in [-2048, 2047].
  - S-type: imm in [-2048, 2047].
  - B-type: imm in [-4096, 4094] and imm[0]=0.
  - J-type: imm in [-1048576, 1048574] and imm[0]=0.
  - U-type: imm[11:0]=0.
  - Shifts: imm in [0, 31].
  - Illegal op index: out_err=1.
  - R-type: no immediate check.
- Reset (rst_n=0 at a clock edge):
  - s1_valid=0, s2_valid=0, out_valid=0, out_err=0, out_instr=0, err_count=0.
  - in_ready=1 from the first cycle after reset.
  - In-flight requests are discarded; there is no partial output.
- Simultaneous S2 drain and S1 refill in the same cycle is lossless and preserves order.

Optional Feature:
- Macro: RV_ENC_ERR_COUNT_EN.
- Defined:
  - err_count port exists.
  - Increments by 1 on each output handshake (out_valid && out_ready) with out_err=1.
  - Saturates at all-ones; resets to 0.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- ADDI (op 18) rd=1 rs1=0 imm=5 -> out_instr 0x00500093, out_err=0, out_valid 2 cycles after acceptance.
- SUB (op 28) rd=3 rs1=1 rs2=2 -> 0x402081B3; SRAI (op 26) rd=5 rs1=6 imm=3 -> 0x40335293; JAL (op 2) rd=1 imm=8 -> 0x008000EF.
- Errors: ADDI imm=2048, BEQ imm=3, op=40, LUI imm=0x00001001 -> each out_err=1, out_instr=0; with RV_ENC_ERR_COUNT_EN, err_count=4.
- Backpressure: 4 back-to-back requests with out_ready=0 -> in_ready drops after 2 accepted; out_instr stable. Raise out_ready -> all 4 words delivered in order with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 for 1 cycle with both stages full -> out_valid=0 next cycle, in_ready=1, no stale word emitted afterwards.
- Streaming: 100 random legal requests with random out_ready -> outputs match the golden encoder 1:1 in order.
